aurora_tx_lane_framer: RTL and testbench

- Transmit-side framer between the user AXI-stream-like data interface and the per-lane 8b/10b encoders.
- Accepts 64-bit beats and wraps each frame in Start/End Channel PDU ordered sets (SCP/ECP).
- Serializes each beat into bytes and distributes them over one selected lane (single-lane mode) or striped over all lanes (multi-lane mode).
- Unused lanes and inter-frame gaps carry IDLE characters.

---
 rtl/aurora_tx_lane_framer.sv | 117 +++++++++++
 tb/tb_aurora_tx_lane_framer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_lane_framer.sv
// aurora_tx_lane_framer: wraps AXI-stream beats in SCP/ECP ordered sets and serialises them over one or all lanes.
// Define AURORA_TX_LSB_FIRST_EN to send the least significant byte of each beat first.
module aurora_tx_lane_framer #(
   parameter int AXI_DATA_SIZE        = 64,
   parameter int MAX_LINKS            = 4,
   parameter int MAX_LINKS_SIZE       = 2,
   parameter int ENCODER_DATA_IN_SIZE = 8
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 single_lane_i,
   input  logic [MAX_LINKS_SIZE-1:0]                            lane_select_i,
   input  logic                                                 axi_valid_i,
   input  logic                                                 axi_last_i,
   input  logic [AXI_DATA_SIZE-1:0]                             axi_data_i,
   output logic                                                 axi_ready_o,
   output logic [MAX_LINKS-1:0]                                 ctrl_out_o,
   output logic [MAX_LINKS-1:0][ENCODER_DATA_IN_SIZE-1:0]       data_out_o
);
   localparam int ED = ENCODER_DATA_IN_SIZE;
   localparam int NB = AXI_DATA_SIZE / ED;
   localparam int NC = NB / MAX_LINKS;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [ED-1:0] K_IDLE = ED'(8'hBC);
   localparam logic [ED-1:0] K_SCP0 = ED'(8'h5C);
   localparam logic [ED-1:0] K_SCP1 = ED'(8'hFB);
   localparam logic [ED-1:0] K_ECP0 = ED'(8'hFD);
   localparam logic [ED-1:0] K_ECP1 = ED'(8'hFE);

   typedef enum logic [2:0] {S_IDLE, S_SCP0, S_SCP1, S_DATA, S_ECP0, S_ECP1} state_t;

   state_t                        state_q, state_d;
   logic [AXI_DATA_SIZE-1:0]      buf_q;
   logic                          buf_last_q, buf_valid_q, end_q, single_q;
   logic [MAX_LINKS_SIZE-1:0]     lane_q, lane_in, lane_act;
   logic [CW-1:0]                 cnt_q;
   logic [MAX_LINKS-1:0]          ctrl_q, ctrl_d;
   logic [MAX_LINKS-1:0][ED-1:0]  data_q, data_d;
   logic                          single_act, last_chunk, emit, fin, accept;
   logic [ED-1:0]                 ch;

   function automatic logic [ED-1:0] pick(input logic [AXI_DATA_SIZE-1:0] d, input int p);
      logic [AXI_DATA_SIZE-1:0] s;
`ifdef AURORA_TX_LSB_FIRST_EN
      s = d >> (ED * p);
`else
      s = d >> (AXI_DATA_SIZE - ED - ED * p);
`endif
      return s[ED-1:0];
   endfunction

   // The output register holds what the state being entered emits, so SCP0 shows one cycle after leaving IDLE.
   always_comb begin
      lane_in    = ({1'b0, lane_select_i} >= (MAX_LINKS_SIZE+1)'(MAX_LINKS)) ? '0 : lane_select_i;
      single_act = (state_q == S_IDLE) ? single_lane_i : single_q;
      lane_act   = (state_q == S_IDLE) ? lane_in : lane_q;
      last_chunk = cnt_q == (single_act ? CW'(NB - 1) : CW'(NC - 1));
      emit       = buf_valid_q && (state_q == S_SCP1 || (state_q == S_DATA && !end_q));
      fin        = emit && last_chunk;
      axi_ready_o = rst_n && (!buf_valid_q || fin);
      accept     = axi_valid_i && axi_ready_o;
      state_d    = state_q;
      case (state_q)
         S_IDLE:  state_d = buf_valid_q ? S_SCP0 : S_IDLE;
         S_SCP0:  state_d = S_SCP1;
         S_SCP1:  state_d = S_DATA;
         S_DATA:  state_d = end_q ? S_ECP0 : S_DATA;
         S_ECP0:  state_d = S_ECP1;
         default: state_d = S_IDLE;
      endcase
      ch = (state_d == S_SCP0) ? K_SCP0 :
           (state_d == S_SCP1) ? K_SCP1 :
           (state_d == S_ECP0) ? K_ECP0 :
           (state_d == S_ECP1) ? K_ECP1 : K_IDLE;
      for (int l = 0; l < MAX_LINKS; l++) begin
         data_d[l] = K_IDLE;
         ctrl_d[l] = 1'b1;
         if (!single_act || lane_act == MAX_LINKS_SIZE'(l)) begin
            data_d[l] = emit ? pick(buf_q, single_act ? int'(cnt_q) : int'(cnt_q) * MAX_LINKS + l) : ch;
            ctrl_d[l] = !emit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         buf_q       <= '0;
         buf_last_q  <= 1'b0;
         buf_valid_q <= 1'b0;
         end_q       <= 1'b0;
         single_q    <= 1'b0;
         lane_q      <= '0;
         cnt_q       <= '0;
         data_q      <= {MAX_LINKS{K_IDLE}};
         ctrl_q      <= '1;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         ctrl_q      <= ctrl_d;
         end_q       <= fin && buf_last_q;
         buf_valid_q <= accept || (buf_valid_q && !fin);
         if (accept) begin
            buf_q      <= axi_data_i;
            buf_last_q <= axi_last_i;
         end
         if (emit) cnt_q <= last_chunk ? '0 : cnt_q + CW'(1);
         if (state_q == S_IDLE && buf_valid_q) begin
            single_q <= single_lane_i;
            lane_q   <= lane_in;
         end
      end
   end

   assign data_out_o = data_q;
   assign ctrl_out_o = ctrl_q;
endmodule

// File: tb/tb_aurora_tx_lane_framer.sv
// tb_aurora_tx_lane_framer: scoreboard bench; a byte-stream model predicts every non-idle lane word.
module tb_aurora_tx_lane_framer;
   localparam int ML = 4;

   logic               clk = 1'b0, rst_n = 1'b0, single_lane = 1'b0, axi_valid = 1'b0, axi_last = 1'b0, axi_ready;
   logic [1:0]         lane_select = 2'd0;
   logic [63:0]        axi_data = '0;
   logic [ML-1:0]      ctrl_out;
   logic [ML-1:0][7:0] data_out;
   int                 tests = 0, fails = 0, cyc = 0, acc;

   typedef struct {logic [ML-1:0] c; logic [ML-1:0][7:0] d; int t;} exp_t;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [63:0] frame_q[$];
   int          gap_q[$];

   aurora_tx_lane_framer dut (
      .clk(clk), .rst_n(rst_n), .single_lane_i(single_lane), .lane_select_i(lane_select),
      .axi_valid_i(axi_valid), .axi_last_i(axi_last), .axi_data_i(axi_data),
      .axi_ready_o(axi_ready), .ctrl_out_o(ctrl_out), .data_out_o(data_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (ctrl_out !== '1 || data_out !== {ML{8'hBC}})) begin
         if (sb.size() == 0) check("unexpected_output", 64'({ctrl_out, data_out}), 64'({4'hF, {ML{8'hBC}}}));
         else begin
            mon_e = sb.pop_front();
            check("lane_word", 64'({ctrl_out, data_out}), 64'({mon_e.c, mon_e.d}));
            if (mon_e.t >= 0) check("scp_latency", 64'(cyc), 64'(mon_e.t));
         end
      end
   end

   function automatic exp_t word(input logic sl, input logic [1:0] ls, input logic [7:0] ch, input logic k);
      exp_t w;
      w.t = -1;
      for (int l = 0; l < ML; l++) begin
         w.d[l] = (!sl || l == int'(ls)) ? ch : 8'hBC;
         w.c[l] = (!sl || l == int'(ls)) ? k : 1'b1;
      end
      return w;
   endfunction

   task automatic push_frame(input logic sl, input logic [1:0] ls, input int t0);
      logic [7:0] bytes[$];
      exp_t w;
      foreach (frame_q[i]) begin
         for (int b = 0; b < 8; b++) begin
`ifdef AURORA_TX_LSB_FIRST_EN
            bytes.push_back(frame_q[i][8*b +: 8]);
`else
            bytes.push_back(frame_q[i][56-8*b +: 8]);
`endif
         end
      end
      w = word(sl, ls, 8'h5C, 1'b1);
      w.t = t0;
      sb.push_back(w);
      sb.push_back(word(sl, ls, 8'hFB, 1'b1));
      if (sl) foreach (bytes[i]) sb.push_back(word(1'b1, ls, bytes[i], 1'b0));
      else for (int i = 0; i < bytes.size(); i += ML) begin
         w = word(1'b0, ls, 8'h00, 1'b0);
         for (int k = 0; k < ML; k++) w.d[k] = bytes[i+k];
         sb.push_back(w);
      end
      sb.push_back(word(sl, ls, 8'hFD, 1'b1));
      sb.push_back(word(sl, ls, 8'hFE, 1'b1));
   endtask

   task automatic send(input logic [63:0] d, input logic l, output int a);
      bit ok = 1'b0;
      axi_valid = 1'b1;
      axi_data  = d;
      axi_last  = l;
      a = -1;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         ok = axi_ready;
         a = cyc;
         @(posedge clk);
         #1;
      end
      if (!ok) check("accept_timeout", 64'(ok), 64'(1));
      axi_valid = 1'b0;
      axi_last  = 1'($urandom);
      axi_data  = {$urandom, $urandom};
   endtask

   // Mode inputs may change only once the frame has certainly left IDLE.
   task automatic send_frame(input logic sl, input logic [1:0] ls, input logic msl, input logic [1:0] mls, input bit tag);
      int a;
      single_lane = sl;
      lane_select = ls;
      foreach (frame_q[j]) begin
         repeat (gap_q[j]) begin @(posedge clk); #1; end
         send(frame_q[j], j == frame_q.size() - 1, a);
         if (j == 0) begin
            push_frame(sl, ls, tag ? a + 2 : -1);
            repeat (6) begin @(posedge clk); #1; end
            single_lane = msl;
            lane_select = mls;
         end
      end
   endtask

   task automatic rand_frame(input int n, input int gmax);
      frame_q.delete();
      gap_q.delete();
      for (int j = 0; j < n; j++) begin
         frame_q.push_back({$urandom, $urandom});
         gap_q.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, gmax)) : 0);
      end
   endtask

   task automatic ready_back(input int a, input int lat);
      int t = -1;
      for (int n = 0; n < 100 && t < 0; n++) begin
         @(negedge clk);
         if (axi_ready) t = cyc;
      end
      check("ready_return", 64'(t - a), 64'(lat));
   endtask

   task automatic drain();
      for (int n = 0; n < 400 && sb.size() != 0; n++) @(posedge clk);
      check("drain", 64'(sb.size()), 64'(0));
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_data", 64'(data_out), 64'({ML{8'hBC}}));
      check("reset_ctrl", 64'(ctrl_out), 64'(4'hF));
      check("reset_ready", 64'(axi_ready), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("idle_data", 64'(data_out), 64'({ML{8'hBC}}));
      check("idle_ready", 64'(axi_ready), 64'(1));
      @(posedge clk); #1;

      single_lane = 1'b1; lane_select = 2'd0;
      frame_q = '{64'hDEADB00D_00000000};
      send(frame_q[0], 1'b1, acc);
      push_frame(1'b1, 2'd0, acc + 2);
      ready_back(acc, 10);
      drain();

      single_lane = 1'b0;
      send(frame_q[0], 1'b1, acc);
      push_frame(1'b0, 2'd0, acc + 2);
      ready_back(acc, 4);
      drain();

      frame_q.delete(); gap_q.delete();
      for (int j = 0; j < 7; j++) begin
         frame_q.push_back({32'hDEADB00D, 32'(j)});
         gap_q.push_back((j >= 2 && j <= 5) ? 12 : 0);
      end
      send_frame(1'b1, 2'd2, 1'b1, 2'd2, 1'b1);
      drain();

      rand_frame(3, 0);
      send_frame(1'b1, 2'd0, 1'b1, 2'd3, 1'b1);
      rand_frame(2, 0);
      send_frame(1'b1, 2'd3, 1'b1, 2'd3, 1'b0);
      drain();

      single_lane = 1'b0;
      frame_q = '{64'h0123_4567_89AB_CDEF};
      send(frame_q[0], 1'b0, acc);
      push_frame(1'b0, 2'd0, acc + 2);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset_data", 64'(data_out), 64'({ML{8'hBC}}));
      check("async_reset_ctrl", 64'(ctrl_out), 64'(4'hF));
      check("async_reset_ready", 64'(axi_ready), 64'(0));
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;

      for (int f = 0; f < 30; f++) begin
         rand_frame(int'($urandom_range(1, 4)), 12);
         send_frame(1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom), 1'b0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
